// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and constants for the I2S receive deserializer
//
// Purpose: FSM state encodings, synchronizer depth and channel encoding used by
//          i2s_rx_deserializer and i2s_edge_sync.
// Ports:   none (package).
package i2s_pkg;

  // Depth of the metastability synchronizer on every codec pin.
  localparam int SYNC_STAGES = 2;

  // Receive FSM states.
  typedef logic [1:0] state_t;
  localparam state_t ALIGN = 2'd0;
  localparam state_t DELAY = 2'd1;
  localparam state_t SHIFT = 2'd2;
  localparam state_t WAIT  = 2'd3;

  // Channel encoding matches the lrclk level of the slot.
  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } channel_e;

endpackage

// File: rtl/i2s_rx_deserializer_if.sv
// rtl/i2s_rx_deserializer_if.sv - sample-pair valid/ready handshake bundle
//
// Purpose: carries one left/right sample pair from the deserializer to the
//          visualizer sample buffer.
// Signals: left_sample, right_sample (SAMPLE_WIDTH, two's complement),
//          sample_valid (pair held), sample_ready (consumer accepts).
// Modports: master = producer (deserializer), slave = consumer.
interface i2s_rx_deserializer_if #(
  parameter int SAMPLE_WIDTH = 16
);

  logic [SAMPLE_WIDTH-1:0] left_sample;
  logic [SAMPLE_WIDTH-1:0] right_sample;
  logic                    sample_valid;
  logic                    sample_ready;

  modport master (
    output left_sample,
    output right_sample,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  left_sample,
    input  right_sample,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/i2s_edge_sync.sv
// rtl/i2s_edge_sync.sv - multi-bit pin synchronizer with edge detection
//
// Purpose: passes W asynchronous pins through a SYNC_STAGES-flop synchronizer
//          and a previous-value register, then derives per-bit edge strobes.
// Ports:   clk, reset (sync, active-high)
//          din      [W] asynchronous pin levels
//          level    [W] synchronized level
//          rise     [W] one-clk strobe on synchronized 0->1
//          any_edge [W] one-clk strobe on any synchronized change
module i2s_edge_sync
  import i2s_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] level,
  output logic [W-1:0] rise,
  output logic [W-1:0] any_edge
);

  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] sync_d [SYNC_STAGES];
  logic [W-1:0] prev_q;
  logic [W-1:0] prev_d;

  always_comb begin
    sync_d[0] = din;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q <= prev_d;
    end
  end

  assign level    = sync_q[SYNC_STAGES-1];
  assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign any_edge = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/i2s_rx_deserializer.sv
// rtl/i2s_rx_deserializer.sv - I2S ADC stream to parallel left/right pairs
//
// Purpose: oversamples the codec I2S pins in the clk domain, aligns to the
//          lrclk falling edge, captures SAMPLE_WIDTH bits MSB-first per slot
//          (after the one-bit I2S delay) and presents complete pairs on a
//          valid/ready handshake. Pairs arriving while a held pair is not
//          accepted are dropped and flagged in the sticky overflow bit.
// Ports:   clk, reset (sync, active-high)
//          bclk, lrclk, adcdat  asynchronous codec pins
//          smp                  i2s_rx_deserializer_if.master pair output
//          overflow             sticky dropped-pair flag
//          overflow_count [16]  saturating dropped-pair count, present only
//                               when I2S_RX_OVERFLOW_CNT_EN is defined
module i2s_rx_deserializer
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          bclk,
  input  logic                          lrclk,
  input  logic                          adcdat,
  i2s_rx_deserializer_if.master         smp,
`ifdef I2S_RX_OVERFLOW_CNT_EN
  output logic [15:0]                   overflow_count,
`endif
  output logic                          overflow
);

  localparam int CNT_W = $clog2(SAMPLE_WIDTH) + 1;

  if (SLOT_WIDTH < SAMPLE_WIDTH + 1) begin : g_bad_slot
    $error("SLOT_WIDTH must be at least SAMPLE_WIDTH+1");
  end

  // Pin synchronization: bit 0 = bclk, bit 1 = lrclk, bit 2 = adcdat.
  logic [2:0] pin_level;
  logic [2:0] pin_rise;
  logic [2:0] pin_edge;

  i2s_edge_sync #(
    .W(3)
  ) u_edge_sync (
    .clk      (clk),
    .reset    (reset),
    .din      ({adcdat, lrclk, bclk}),
    .level    (pin_level),
    .rise     (pin_rise),
    .any_edge (pin_edge)
  );

  logic bclk_rise;
  logic lrclk_edge;
  logic lrclk_lvl;
  logic adc_bit;
  logic unused_sync_bits;

  assign bclk_rise  = pin_rise[0];
  assign lrclk_edge = pin_edge[1];
  assign lrclk_lvl  = pin_level[1];
  assign adc_bit    = pin_level[2];
  assign unused_sync_bits = ^{pin_level[0], pin_rise[2:1], pin_edge[2], pin_edge[0]};

  // Receive state.
  state_t                  state_q,     state_d;
  channel_e                channel_q,   channel_d;
  logic [CNT_W-1:0]        bit_cnt_q,   bit_cnt_d;
  logic [SAMPLE_WIDTH-1:0] shreg_q,     shreg_d;
  logic [SAMPLE_WIDTH-1:0] left_hold_q, left_hold_d;
  logic                    left_done_q, left_done_d;

  // Output side.
  logic [SAMPLE_WIDTH-1:0] left_out_q,  left_out_d;
  logic [SAMPLE_WIDTH-1:0] right_out_q, right_out_d;
  logic                    valid_q,     valid_d;
  logic                    overflow_q,  overflow_d;
`ifdef I2S_RX_OVERFLOW_CNT_EN
  logic [15:0]             ovf_cnt_q,   ovf_cnt_d;
`endif

  logic [SAMPLE_WIDTH-1:0] shifted;
  logic                    pair_done;
  logic                    transfer;

  assign shifted  = {shreg_q[SAMPLE_WIDTH-2:0], adc_bit};
  assign transfer = valid_q & smp.sample_ready;

  // Receive FSM. lrclk changes on the bclk falling edge, so its synchronized
  // edge never coincides with bclk_rise; acting on the edge directly lets
  // DELAY consume exactly the first rising edge of the new slot, which is
  // the I2S one-bit delay. Data handling is gated by bclk_rise.
  always_comb begin
    state_d     = state_q;
    channel_d   = channel_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    left_hold_d = left_hold_q;
    left_done_d = left_done_q;
    pair_done   = 1'b0;

    if (lrclk_edge) begin
      if (state_q == ALIGN) begin
        if (!lrclk_lvl) begin
          state_d   = DELAY;
          channel_d = LEFT;
        end
      end else begin
        state_d   = DELAY;
        channel_d = channel_e'(~channel_q);
        // Short slot: the partial word is abandoned with its done bit.
        if (state_q == SHIFT && channel_q == LEFT) begin
          left_done_d = 1'b0;
        end
      end
    end else if (bclk_rise) begin
      case (state_q)
        DELAY: begin
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
        SHIFT: begin
          shreg_d   = shifted;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(SAMPLE_WIDTH - 1)) begin
            state_d = WAIT;
            if (channel_q == LEFT) begin
              left_hold_d = shifted;
              left_done_d = 1'b1;
            end else if (left_done_q) begin
              // Right word completes the pair straight from the shifter.
              pair_done   = 1'b1;
              left_done_d = 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output holding register and overflow accounting.
  always_comb begin
    left_out_d  = left_out_q;
    right_out_d = right_out_q;
    valid_d     = valid_q;
    overflow_d  = overflow_q;
`ifdef I2S_RX_OVERFLOW_CNT_EN
    ovf_cnt_d   = ovf_cnt_q;
`endif

    if (pair_done) begin
      if (!valid_q || smp.sample_ready) begin
        // Loading while the held pair transfers keeps valid high.
        left_out_d  = left_hold_q;
        right_out_d = shifted;
        valid_d     = 1'b1;
      end else begin
        overflow_d = 1'b1;
`ifdef I2S_RX_OVERFLOW_CNT_EN
        if (ovf_cnt_q != 16'hFFFF) begin
          ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
`endif
      end
    end else if (transfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ALIGN;
      channel_q   <= LEFT;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      left_hold_q <= '0;
      left_done_q <= 1'b0;
      left_out_q  <= '0;
      right_out_q <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef I2S_RX_OVERFLOW_CNT_EN
      ovf_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      channel_q   <= channel_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      left_hold_q <= left_hold_d;
      left_done_q <= left_done_d;
      left_out_q  <= left_out_d;
      right_out_q <= right_out_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
`ifdef I2S_RX_OVERFLOW_CNT_EN
      ovf_cnt_q   <= ovf_cnt_d;
`endif
    end
  end

  assign smp.left_sample  = left_out_q;
  assign smp.right_sample = right_out_q;
  assign smp.sample_valid = valid_q;
  assign overflow         = overflow_q;
`ifdef I2S_RX_OVERFLOW_CNT_EN
  assign overflow_count   = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// tb/tb_i2s_rx_deserializer.sv - scoreboard bench for i2s_rx_deserializer
module tb_i2s_rx_deserializer;

  localparam int SW = 16;

  logic clk = 1'b0;
  logic reset;
  logic bclk, lrclk, adcdat;
  logic overflow;
`ifdef I2S_RX_OVERFLOW_CNT_EN
  logic [15:0] overflow_count;
`endif

  i2s_rx_deserializer_if #(.SAMPLE_WIDTH(SW)) smp_if ();

  i2s_rx_deserializer #(
    .SAMPLE_WIDTH(SW),
    .SLOT_WIDTH  (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bclk          (bclk),
    .lrclk         (lrclk),
    .adcdat        (adcdat),
    .smp           (smp_if.master),
`ifdef I2S_RX_OVERFLOW_CNT_EN
    .overflow_count(overflow_count),
`endif
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];
  logic        arm_ready = 1'b0;
  logic [15:0] arm_left  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bclk period = 8 clk; lrclk and data change with the falling edge.
  task automatic send_bit(input logic lr, input logic d, input logic rel);
    bclk = 1'b0; lrclk = lr; adcdat = d;
    repeat (4) tick();
    bclk = 1'b1;
    if (rel) begin
      // Raise ready in the cycle the new pair completes: held pair transfers
      // and the new one loads with no bubble.
      tick(); tick();
      smp_if.sample_ready = 1'b1;
      tick();
      check("no_bubble_valid", 32'(smp_if.sample_valid), 32'd1);
      check("no_bubble_left", 32'(smp_if.left_sample), 32'(arm_left));
      tick();
    end else begin
      repeat (4) tick();
    end
  endtask

  task automatic send_slot(input logic lr, input logic [15:0] w, input int first, input int last);
    logic d;
    for (int i = first; i <= last; i++) begin
      d = (i >= 1 && i <= SW) ? w[SW-i] : 1'($urandom_range(0, 1));
      send_bit(lr, d, arm_ready && lr && (i == SW));
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b0, l, 0, 31);
    send_slot(1'b1, r, 0, 31);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) tick();
    check(tag, 32'(sb_q.size()), 32'd0);
  endtask

  // Scoreboard consumer: every transfer must match the oldest expected pair.
  always @(negedge clk) begin
    if (!reset && smp_if.sample_valid && smp_if.sample_ready) begin
      if (sb_q.size() == 0) begin
        check("spurious_xfer", {smp_if.left_sample, smp_if.right_sample}, 32'hxxxx_xxxx);
      end else begin
        check("pair", {smp_if.left_sample, smp_if.right_sample}, sb_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; bclk = 1'b0; lrclk = 1'b1; adcdat = 1'b0;
    smp_if.sample_ready = 1'b0;
    repeat (5) tick();
    reset = 1'b0;
    tick();
    check("rst_left", 32'(smp_if.left_sample), 32'd0);
    check("rst_right", 32'(smp_if.right_sample), 32'd0);
    check("rst_valid", 32'(smp_if.sample_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
`ifdef I2S_RX_OVERFLOW_CNT_EN
    check("rst_ovf_cnt", 32'(overflow_count), 32'd0);
`endif

    // Nominal frame.
    smp_if.sample_ready = 1'b1;
    sb_q.push_back({16'h1234, 16'hBEEF});
    send_frame(16'h1234, 16'hBEEF);
    drain("nominal_drain");
    check("nominal_overflow", 32'(overflow), 32'd0);

    // Start mid-frame: reset released inside a right slot.
    reset = 1'b1;
    send_slot(1'b1, 16'hDEAD, 0, 4);
    reset = 1'b0;
    send_slot(1'b1, 16'hDEAD, 5, 31);
    check("midframe_novalid", 32'(smp_if.sample_valid), 32'd0);
    sb_q.push_back({16'hA5A5, 16'h5A5A});
    send_frame(16'hA5A5, 16'h5A5A);
    drain("midframe_drain");

    // Backpressure: A held, B dropped.
    smp_if.sample_ready = 1'b0;
    sb_q.push_back({16'h0001, 16'h8000});
    send_frame(16'h0001, 16'h8000);
    send_frame(16'h7FFF, 16'hFFFF);
    check("bp_valid", 32'(smp_if.sample_valid), 32'd1);
    check("bp_overflow", 32'(overflow), 32'd1);
    check("bp_held_right", 32'(smp_if.right_sample), 32'h8000);
`ifdef I2S_RX_OVERFLOW_CNT_EN
    check("bp_ovf_cnt", 32'(overflow_count), 32'd1);
`endif
    smp_if.sample_ready = 1'b1;
    drain("bp_drain");
    tick();
    check("bp_valid_after", 32'(smp_if.sample_valid), 32'd0);

    // Back-to-back frames, each transferring once.
    sb_q.push_back({16'hC0C0, 16'h0C0C});
    sb_q.push_back({16'hD00D, 16'hF00F});
    send_frame(16'hC0C0, 16'h0C0C);
    send_frame(16'hD00D, 16'hF00F);
    drain("b2b_drain");

    // Held pair E replaced by F in the same cycle it transfers.
    smp_if.sample_ready = 1'b0;
    sb_q.push_back({16'h1E1E, 16'h2E2E});
    send_frame(16'h1E1E, 16'h2E2E);
    sb_q.push_back({16'h3F3F, 16'h4F4F});
    arm_ready = 1'b1; arm_left = 16'h3F3F;
    send_frame(16'h3F3F, 16'h4F4F);
    arm_ready = 1'b0;
    drain("load_xfer_drain");
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Short left slot: no pair for that frame.
    send_slot(1'b0, 16'h9999, 0, 10);
    send_slot(1'b1, 16'h6666, 0, 31);
    check("short_novalid", 32'(smp_if.sample_valid), 32'd0);
    sb_q.push_back({16'h2468, 16'h1357});
    send_frame(16'h2468, 16'h1357);
    drain("short_drain");

    // Reset pulse at bit 7 of a left slot.
    send_slot(1'b0, 16'h7777, 0, 7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_left", 32'(smp_if.left_sample), 32'd0);
    check("mrst_right", 32'(smp_if.right_sample), 32'd0);
    check("mrst_valid", 32'(smp_if.sample_valid), 32'd0);
    check("mrst_overflow", 32'(overflow), 32'd0);
`ifdef I2S_RX_OVERFLOW_CNT_EN
    check("mrst_ovf_cnt", 32'(overflow_count), 32'd0);
`endif
    send_slot(1'b0, 16'h7777, 8, 31);
    send_slot(1'b1, 16'h8888, 0, 31);
    check("mrst_novalid", 32'(smp_if.sample_valid), 32'd0);
    sb_q.push_back({16'h0F1E, 16'hC3A5});
    send_frame(16'h0F1E, 16'hC3A5);
    drain("mrst_drain");
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
